// File: rtl/key_input_controller.sv
// -----------------------------------------------------------------------------
// key_input_controller
//
// Multi-key interrupt source running on the frame-rate clock. Each key is
// synchronised, debounced, turned into press events (plus optional
// auto-repeat events while held), queued as one pending bit per key, and
// presented to the CPU one event at a time over a valid/ack handshake.
//
// Ports:
//   frame_rt_clk    frame-rate clock, all state updates on its rising edge
//   reset           asynchronous, active-high reset
//   keys_raw        raw key levels (1 = pressed), asynchronous to the clock
//   key_enable      per-key event enable; 0 masks events and drops pending
//   repeat_en       per-key auto-repeat enable
//   int_ack         CPU acknowledge of the presented event
//   int_valid       an event is being presented
//   int_id          index of the presented key
//   pending         queued events not yet presented
//   overflow        sticky: an event landed on an already-pending key
//   clear_overflow  synchronous clear of overflow (a same-edge set wins)
// -----------------------------------------------------------------------------
module key_input_controller #(
    parameter int N_KEYS        = 4,
    parameter int ID_W          = 2,
    parameter int DEBOUNCE      = 2,
    parameter int REPEAT_DELAY  = 15,
    parameter int REPEAT_PERIOD = 5,
    parameter int CNT_W         = 5
) (
    input  logic              frame_rt_clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_raw,
    input  logic [N_KEYS-1:0] key_enable,
    input  logic [N_KEYS-1:0] repeat_en,
    input  logic              int_ack,
    output logic              int_valid,
    output logic [ID_W-1:0]   int_id,
    output logic [N_KEYS-1:0] pending,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [N_KEYS-1:0] sync_a;
    logic [N_KEYS-1:0] sync_s;
    logic [N_KEYS-1:0] deb_d;
    logic [N_KEYS-1:0] deb_q;
    logic [N_KEYS-1:0] rep_q;
    logic [CNT_W-1:0]  db_cnt   [N_KEYS];
    logic [CNT_W-1:0]  hold_cnt [N_KEYS];

    logic [N_KEYS-1:0] evt;
    logic [N_KEYS-1:0] sel_onehot;
    logic [ID_W-1:0]   sel_id;
    logic              sel_valid;
    logic              load;
    logic [N_KEYS-1:0] load_clr;
    logic              ovf_set;

    // Synchroniser, debounce and hold counters, one slice per key.
    always_ff @(posedge frame_rt_clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_s <= '0;
            deb_d  <= '0;
            deb_q  <= '0;
            rep_q  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync_a <= keys_raw;
            sync_s <= sync_a;
            deb_q  <= deb_d;
            for (int i = 0; i < N_KEYS; i++) begin
                // The edge on which the count would reach DEBOUNCE is the
                // edge that accepts the new level.
                if (sync_s[i] != deb_d[i]) begin
                    if (db_cnt[i] == DB_LAST - 1'b1) begin
                        deb_d[i]  <= sync_s[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end

                // Hold counter: the edge on which it would reach REPEAT_DELAY
                // registers a repeat pulse (like the debounced rise does) and
                // reloads so later repeats are REPEAT_PERIOD frames apart.
                if (deb_d[i] && repeat_en[i]) begin
                    if (hold_cnt[i] == REP_LAST - 1'b1) begin
                        hold_cnt[i] <= REP_RELOAD;
                        rep_q[i]    <= 1'b1;
                    end else begin
                        hold_cnt[i] <= hold_cnt[i] + 1'b1;
                        rep_q[i]    <= 1'b0;
                    end
                end else begin
                    hold_cnt[i] <= '0;
                    rep_q[i]    <= 1'b0;
                end
            end
        end
    end

    assign evt = key_enable & ((deb_d & ~deb_q) | rep_q);

    // Lowest pending index wins.
    always_comb begin
        sel_onehot = '0;
        sel_id     = '0;
        sel_valid  = 1'b0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_id        = ID_W'(i);
                sel_valid     = 1'b1;
            end
        end
    end

    // A new event loads when the output is idle or the current one is acked.
    assign load     = sel_valid && (!int_valid || int_ack);
    assign load_clr = load ? sel_onehot : '0;
    assign ovf_set  = |(evt & pending & ~load_clr);

    always_ff @(posedge frame_rt_clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            int_valid <= 1'b0;
            int_id    <= '0;
            overflow  <= 1'b0;
        end else begin
            // A fresh event on the bit being loaded re-queues it.
            pending <= ((pending & ~load_clr) | evt) & key_enable;

            if (load) begin
                int_valid <= 1'b1;
                int_id    <= sel_id;
            end else if (int_ack) begin
                int_valid <= 1'b0;
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_input_controller.sv
// -----------------------------------------------------------------------------
// tb_key_input_controller
//
// Self-checking bench for key_input_controller. Inputs are driven and outputs
// sampled on the falling edge; "edge e" below is the e-th rising edge after
// stimulus was applied. Expected key ids are queued when a press is driven
// and popped when the DUT presents an event.
// -----------------------------------------------------------------------------
module tb_key_input_controller;

    logic       frame_rt_clk = 1'b0;
    logic       reset;
    logic [3:0] keys_raw;
    logic [3:0] key_enable;
    logic [3:0] repeat_en;
    logic       int_ack;
    logic       int_valid;
    logic [1:0] int_id;
    logic [3:0] pending;
    logic       overflow;
    logic       clear_overflow;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_ids[$];
    int         exp_frames[$];

    always #5 frame_rt_clk = ~frame_rt_clk;

    key_input_controller #(
        .N_KEYS(4), .ID_W(2), .DEBOUNCE(2),
        .REPEAT_DELAY(15), .REPEAT_PERIOD(5), .CNT_W(5)
    ) dut (
        .frame_rt_clk  (frame_rt_clk),
        .reset         (reset),
        .keys_raw      (keys_raw),
        .key_enable    (key_enable),
        .repeat_en     (repeat_en),
        .int_ack       (int_ack),
        .int_valid     (int_valid),
        .int_id        (int_id),
        .pending       (pending),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    task automatic frame();
        @(negedge frame_rt_clk);
    endtask

    task automatic test_reset();
        keys_raw = '0; key_enable = '1; repeat_en = '1;
        int_ack = 1'b0; clear_overflow = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #10;
        n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", int_valid); end
        n_checks++; if (int_id !== 2'd0) begin n_errors++; $display("FAIL reset_id: got %0d want 0", int_id); end
        n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        frame(); frame();
        reset = 1'b0;
        repeat (3) frame();
        n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid: got %b want 0", int_valid); end
    endtask

    task automatic test_single_press();
        logic [1:0] want;
        keys_raw[0] = 1'b1;
        exp_ids.push_back(2'd0);
        for (int e = 1; e <= 8; e++) begin
            frame();
            if (e == 4) begin
                n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL press_pending_early: got %b want 0000", pending); end
            end
            if (e == 5) begin
                n_checks++; if (pending !== 4'b0001) begin n_errors++; $display("FAIL press_pending: got %b want 0001", pending); end
                n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL press_valid_early: got %b want 0", int_valid); end
            end
            if (e == 6) begin
                n_checks++; if (int_valid !== 1'b1) begin n_errors++; $display("FAIL press_valid: got %b want 1", int_valid); end
                n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL press_pending_cleared: got %b want 0000", pending); end
                n_checks++;
                if (exp_ids.size() == 0) begin n_errors++; $display("FAIL press_id: got %0d want <empty queue>", int_id); end
                else begin
                    want = exp_ids.pop_front();
                    if (int_id !== want) begin n_errors++; $display("FAIL press_id: got %0d want %0d", int_id, want); end
                end
            end
            if (e == 7) begin
                n_checks++; if (int_valid !== 1'b1) begin n_errors++; $display("FAIL press_hold: got %b want 1", int_valid); end
                int_ack = 1'b1;
            end
            if (e == 8) begin
                n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL press_ack: got %b want 0", int_valid); end
                int_ack = 1'b0;
            end
        end
        keys_raw[0] = 1'b0;
        repeat (6) frame();
    endtask

    task automatic test_glitch();
        keys_raw[2] = 1'b1;
        frame();
        keys_raw[2] = 1'b0;
        for (int e = 2; e <= 9; e++) begin
            frame();
            n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL glitch_pending e%0d: got %b want 0000", e, pending); end
            n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL glitch_valid e%0d: got %b want 0", e, int_valid); end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] want;
        int         seen_at;
        seen_at = 0;
        keys_raw[1] = 1'b1; keys_raw[3] = 1'b1;
        exp_ids.push_back(2'd1); exp_ids.push_back(2'd3);
        for (int e = 1; e <= 12 && seen_at == 0; e++) begin
            frame();
            if (int_valid === 1'b1) seen_at = e;
        end
        n_checks++; if (seen_at != 6) begin n_errors++; $display("FAIL simul_latency: got edge %0d want 6", seen_at); end
        n_checks++;
        want = (exp_ids.size() != 0) ? exp_ids.pop_front() : 2'bxx;
        if (int_id !== want) begin n_errors++; $display("FAIL simul_first_id: got %0d want %0d", int_id, want); end
        n_checks++; if (pending !== 4'b1000) begin n_errors++; $display("FAIL simul_pending: got %b want 1000", pending); end
        int_ack = 1'b1;
        frame();
        n_checks++; if (int_valid !== 1'b1) begin n_errors++; $display("FAIL simul_valid_held: got %b want 1", int_valid); end
        n_checks++;
        want = (exp_ids.size() != 0) ? exp_ids.pop_front() : 2'bxx;
        if (int_id !== want) begin n_errors++; $display("FAIL simul_second_id: got %0d want %0d", int_id, want); end
        n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL simul_pending_empty: got %b want 0000", pending); end
        int_ack = 1'b0;
        frame();
        n_checks++; if (int_valid !== 1'b1 || int_id !== 2'd3) begin n_errors++; $display("FAIL simul_stable: got %b/%0d want 1/3", int_valid, int_id); end
        int_ack = 1'b1;
        frame();
        n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL simul_drain: got %b want 0", int_valid); end
        int_ack = 1'b0;
        keys_raw[1] = 1'b0; keys_raw[3] = 1'b0;
        repeat (6) frame();
    endtask

    // Key 0 raw high for edges 1..38 with immediate acks; events expected at
    // int_valid edges 6 and, with repeat, 21/26/31/36/41.
    task automatic test_repeat(input logic rep, input int n_exp);
        logic [1:0] want;
        int         want_frame;
        int         n_seen;
        n_seen = 0;
        repeat_en[0] = rep;
        exp_frames.push_back(6);
        exp_ids.push_back(2'd0);
        if (rep) begin
            for (int j = 0; j < 5; j++) begin
                exp_frames.push_back(21 + 5 * j);
                exp_ids.push_back(2'd0);
            end
        end
        keys_raw[0] = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            frame();
            if (e == 38) keys_raw[0] = 1'b0;
            if (int_valid === 1'b1 && int_ack === 1'b0) begin
                n_seen++;
                n_checks++;
                want_frame = (exp_frames.size() != 0) ? exp_frames.pop_front() : -1;
                if (e != want_frame) begin n_errors++; $display("FAIL repeat%0d_frame: got edge %0d want %0d", rep, e, want_frame); end
                n_checks++;
                want = (exp_ids.size() != 0) ? exp_ids.pop_front() : 2'bxx;
                if (int_id !== want) begin n_errors++; $display("FAIL repeat%0d_id: got %0d want %0d", rep, int_id, want); end
                int_ack = 1'b1;
            end else begin
                int_ack = 1'b0;
            end
        end
        int_ack = 1'b0;
        n_checks++; if (n_seen != n_exp) begin n_errors++; $display("FAIL repeat%0d_count: got %0d want %0d", rep, n_seen, n_exp); end
        n_checks++; if (exp_frames.size() != 0) begin n_errors++; $display("FAIL repeat%0d_missing: got %0d left want 0", rep, exp_frames.size()); end
        exp_frames.delete();
        exp_ids.delete();
        repeat_en[0] = 1'b1;
        repeat (4) frame();
    endtask

    // Three presses of key 1 (raw edges 1-5, 11-15, 21-27) without ack.
    task automatic test_overflow();
        logic [1:0] want;
        int         nx;
        exp_ids.push_back(2'd1);
        exp_ids.push_back(2'd1);
        keys_raw[1] = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            frame();
            nx = e + 1;
            keys_raw[1] = (nx <= 5) || (nx >= 11 && nx <= 15) || (nx >= 21 && nx <= 27);
            if (e == 6) begin
                n_checks++;
                want = (exp_ids.size() != 0) ? exp_ids.pop_front() : 2'bxx;
                if (int_valid !== 1'b1 || int_id !== want) begin n_errors++; $display("FAIL ovf_first: got %b/%0d want 1/%0d", int_valid, int_id, want); end
            end
            if (e == 15) begin
                n_checks++; if (pending !== 4'b0010) begin n_errors++; $display("FAIL ovf_queued: got %b want 0010", pending); end
                n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_early15: got %b want 0", overflow); end
            end
            if (e == 24) begin
                n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_early24: got %b want 0", overflow); end
            end
            if (e == 25) begin
                n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
                n_checks++; if (pending !== 4'b0010) begin n_errors++; $display("FAIL ovf_single_entry: got %b want 0010", pending); end
            end
            if (e == 27) clear_overflow = 1'b1;
            if (e == 28) begin
                n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
                clear_overflow = 1'b0;
            end
        end
        int_ack = 1'b1;
        frame();
        n_checks++;
        want = (exp_ids.size() != 0) ? exp_ids.pop_front() : 2'bxx;
        if (int_valid !== 1'b1 || int_id !== want) begin n_errors++; $display("FAIL ovf_requeued: got %b/%0d want 1/%0d", int_valid, int_id, want); end
        n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL ovf_pending_drained: got %b want 0000", pending); end
        frame();
        n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drain: got %b want 0", int_valid); end
        int_ack = 1'b0;
        repeat (4) frame();
    endtask

    task automatic test_enable_mask();
        logic [1:0] want;
        key_enable[3] = 1'b0;
        keys_raw[3] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            frame();
            n_checks++; if (pending !== 4'b0000 || int_valid !== 1'b0) begin n_errors++; $display("FAIL mask_e%0d: got %b/%b want 0000/0", e, pending, int_valid); end
        end
        keys_raw[3] = 1'b0;
        repeat (6) frame();
        key_enable[3] = 1'b1;

        keys_raw[0] = 1'b1; keys_raw[2] = 1'b1;
        exp_ids.push_back(2'd0);
        for (int e = 1; e <= 6; e++) begin
            frame();
            if (e == 5) begin
                n_checks++; if (pending !== 4'b0101) begin n_errors++; $display("FAIL mask_both_pending: got %b want 0101", pending); end
            end
        end
        n_checks++;
        want = (exp_ids.size() != 0) ? exp_ids.pop_front() : 2'bxx;
        if (int_valid !== 1'b1 || int_id !== want) begin n_errors++; $display("FAIL mask_present: got %b/%0d want 1/%0d", int_valid, int_id, want); end
        n_checks++; if (pending !== 4'b0100) begin n_errors++; $display("FAIL mask_left: got %b want 0100", pending); end
        key_enable[2] = 1'b0;
        frame();
        n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL mask_drop: got %b want 0000", pending); end
        n_checks++; if (int_valid !== 1'b1 || int_id !== 2'd0) begin n_errors++; $display("FAIL mask_not_withdrawn: got %b/%0d want 1/0", int_valid, int_id); end
        key_enable[2] = 1'b1;
        keys_raw[0] = 1'b0; keys_raw[2] = 1'b0;
        int_ack = 1'b1;
        frame();
        n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL mask_ack: got %b want 0", int_valid); end
        int_ack = 1'b0;
        repeat (6) frame();
    endtask

    task automatic test_reset_mid();
        logic [1:0] want;
        keys_raw[0] = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            frame();
            if (e == 6) begin keys_raw[1] = 1'b1; keys_raw[2] = 1'b1; end
        end
        n_checks++; if (pending !== 4'b0110) begin n_errors++; $display("FAIL rmid_pending: got %b want 0110", pending); end
        n_checks++; if (int_valid !== 1'b1 || int_id !== 2'd0) begin n_errors++; $display("FAIL rmid_valid: got %b/%0d want 1/0", int_valid, int_id); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (int_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_async_valid: got %b want 0", int_valid); end
        n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL rmid_async_pending: got %b want 0000", pending); end
        n_checks++; if (int_id !== 2'd0 || overflow !== 1'b0) begin n_errors++; $display("FAIL rmid_async_id_ovf: got %0d/%b want 0/0", int_id, overflow); end
        keys_raw[0] = 1'b0; keys_raw[1] = 1'b0;
        exp_ids.delete();
        frame(); frame();
        reset = 1'b0;
        exp_ids.push_back(2'd2);
        for (int e = 1; e <= 6; e++) begin
            frame();
            if (e == 5) begin
                n_checks++; if (pending !== 4'b0100 || int_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_repend: got %b/%b want 0100/0", pending, int_valid); end
            end
        end
        n_checks++;
        want = (exp_ids.size() != 0) ? exp_ids.pop_front() : 2'bxx;
        if (int_valid !== 1'b1 || int_id !== want) begin n_errors++; $display("FAIL rmid_fresh: got %b/%0d want 1/%0d", int_valid, int_id, want); end
        int_ack = 1'b1;
        frame();
        n_checks++; if (int_valid !== 1'b0 || pending !== 4'b0000) begin n_errors++; $display("FAIL rmid_no_release_evt: got %b/%b want 0/0000", int_valid, pending); end
        int_ack = 1'b0;
        keys_raw[2] = 1'b0;
        repeat (6) frame();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_repeat(1'b1, 6);
        test_repeat(1'b0, 1);
        test_overflow();
        test_enable_mask();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
